// File: rtl/snitch_narrow_mem_pkg.sv
// Shared widths, channel payload structs and FSM state encoding for the narrow scratch-memory responder.
package snitch_narrow_mem_pkg;

   localparam int unsigned AddrW = 32;
   localparam int unsigned DataW = 64;
   localparam int unsigned IdW   = 4;
   localparam int unsigned StrbW = DataW / 8;
   localparam int unsigned OffW  = $clog2(StrbW);

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE      = 2'd1,
      WRITE_RESP = 2'd2,
      READ       = 2'd3
   } state_e;

   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [AddrW-1:0] addr;
      logic [7:0]       len;
      logic [2:0]       size;
      logic [1:0]       burst;
   } ax_chan_t;

   typedef struct packed {
      logic [DataW-1:0] data;
      logic [StrbW-1:0] strb;
      logic             last;
   } w_chan_t;

   typedef struct packed {
      logic [IdW-1:0] id;
      logic [1:0]     resp;
   } b_chan_t;

   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [DataW-1:0] data;
      logic [1:0]       resp;
      logic             last;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;

endpackage

// File: rtl/snitch_narrow_mem_if.sv
// Narrow AXI4 request/response bundle between the cluster's narrow_out port and the scratch responder.
interface snitch_narrow_mem_if;
   import snitch_narrow_mem_pkg::*;

   req_t  req;
   resp_t resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);
endinterface

// File: rtl/snitch_axi_burst_addr.sv
// Burst address tracker shared by reads and writes: word index plus out-of-range flag.
// With SNITCH_NARROW_MEM_ERR_EN defined, bursts leaving the window (or WRAP bursts) are flagged.
module snitch_axi_burst_addr
   import snitch_narrow_mem_pkg::*;
#(
   parameter int unsigned      NumWords = 256,
   parameter logic [AddrW-1:0] BaseAddr = '0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        load,
   input  logic [AddrW-1:0]            addr,
   input  logic [7:0]                  len,
   input  logic [2:0]                  size,
   input  logic [1:0]                  burst,
   input  logic                        advance,
   output logic [$clog2(NumWords)-1:0] idx,
   output logic                        oob
);
   localparam int unsigned IdxW = $clog2(NumWords);

   logic [AddrW:0]   diff_c;
   logic [AddrW-1:0] rel_q;
   logic [2:0]       size_q;
   logic             fixed_q;
   logic             oob_q;
   logic             oob_d;

   // Borrow bit of the rebase marks addresses below the window.
   assign diff_c = {1'b0, addr} - {1'b0, BaseAddr};

`ifdef SNITCH_NARROW_MEM_ERR_EN
   logic [AddrW+1:0] span_end_c;
   assign span_end_c = (AddrW+2)'(diff_c[AddrW-1:0])
                     + (((AddrW+2)'(len) + (AddrW+2)'(1)) << size);
   assign oob_d = diff_c[AddrW]
               || (span_end_c > (AddrW+2)'(NumWords * StrbW))
               || (burst == BurstWrap);
`else
   logic unused_cfg;
   assign unused_cfg = ^{len, diff_c[AddrW]};
   assign oob_d      = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rel_q   <= '0;
         size_q  <= '0;
         fixed_q <= 1'b0;
         oob_q   <= 1'b0;
      end else if (load) begin
         rel_q   <= diff_c[AddrW-1:0];
         size_q  <= size;
         fixed_q <= (burst == BurstFixed);
         oob_q   <= oob_d;
      end else if (advance && !fixed_q) begin
         rel_q   <= rel_q + (AddrW'(1) << size_q);
      end
   end

   // Dropping the upper bits makes the index wrap modulo the memory depth.
   assign idx = rel_q[OffW +: IdxW];
   assign oob = oob_q;

endmodule

// File: rtl/snitch_narrow_mem_responder.sv
// AXI4 subordinate terminating the narrow_out port with a flop-based scratch memory, one burst at a time.
// SNITCH_NARROW_MEM_ERR_EN (evaluated in snitch_axi_burst_addr) turns out-of-window bursts into SLVERR.
module snitch_narrow_mem_responder
   import snitch_narrow_mem_pkg::*;
#(
   parameter int unsigned      NumWords = 256,
   parameter logic [AddrW-1:0] BaseAddr = '0
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   snitch_narrow_mem_if.slave axi
);
   localparam int unsigned IdxW = $clog2(NumWords);

   req_t             req;
   resp_t            resp_c;
   state_e           state_q, state_d;
   logic             rr_prio_q, rr_prio_d;
   logic [IdW-1:0]   id_q, id_d;
   logic [7:0]       len_q, len_d;
   logic [7:0]       beat_q, beat_d;
   logic             aw_hs_c, ar_hs_c, w_hs_c, r_hs_c;
   ax_chan_t         ax_c;
   logic [IdxW-1:0]  idx;
   logic             oob;
   logic [DataW-1:0] mem_q [NumWords];

   assign req      = axi.req;
   assign axi.resp = resp_c;
   assign ax_c     = ar_hs_c ? req.ar : req.aw;

   snitch_axi_burst_addr #(
      .NumWords (NumWords),
      .BaseAddr (BaseAddr)
   ) i_burst_addr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load    (aw_hs_c | ar_hs_c),
      .addr    (ax_c.addr),
      .len     (ax_c.len),
      .size    (ax_c.size),
      .burst   (ax_c.burst),
      .advance (w_hs_c | r_hs_c),
      .idx     (idx),
      .oob     (oob)
   );

   // Next-state and handshake decode; rr_prio_q==0 means the write side wins a tie.
   always_comb begin
      state_d   = state_q;
      rr_prio_d = rr_prio_q;
      id_d      = id_q;
      len_d     = len_q;
      beat_d    = beat_q;
      aw_hs_c   = 1'b0;
      ar_hs_c   = 1'b0;
      w_hs_c    = 1'b0;
      r_hs_c    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req.aw_valid && (!req.ar_valid || !rr_prio_q)) begin
               aw_hs_c = 1'b1;
            end else if (req.ar_valid) begin
               ar_hs_c = 1'b1;
            end
            if (req.aw_valid && req.ar_valid) begin
               rr_prio_d = !rr_prio_q;
            end
            if (aw_hs_c || ar_hs_c) begin
               state_d = aw_hs_c ? WRITE : READ;
               id_d    = ax_c.id;
               len_d   = ax_c.len;
               beat_d  = 8'd0;
            end
         end
         WRITE: begin
            w_hs_c = req.w_valid;
            if (w_hs_c) begin
               beat_d = beat_q + 8'd1;
               if (req.w.last) begin
                  state_d = WRITE_RESP;
               end
            end
         end
         WRITE_RESP: begin
            if (req.b_ready) begin
               state_d = IDLE;
            end
         end
         READ: begin
            r_hs_c = req.r_ready;
            if (r_hs_c) begin
               beat_d = beat_q + 8'd1;
               if (beat_q == len_q) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         rr_prio_q <= 1'b0;
         id_q      <= '0;
         len_q     <= '0;
         beat_q    <= '0;
      end else begin
         state_q   <= state_d;
         rr_prio_q <= rr_prio_d;
         id_q      <= id_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
      end
   end

   // Byte-strobed write port; flagged bursts leave the memory untouched.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NumWords; i++) begin
            mem_q[i] <= '0;
         end
      end else if (w_hs_c && !oob) begin
         for (int unsigned b = 0; b < StrbW; b++) begin
            if (req.w.strb[b]) begin
               mem_q[idx][8*b +: 8] <= req.w.data[8*b +: 8];
            end
         end
      end
   end

   // Response channels derive only from flops; payloads read zero outside their state.
   always_comb begin
      resp_c          = '0;
      resp_c.aw_ready = aw_hs_c;
      resp_c.ar_ready = ar_hs_c;
      resp_c.w_ready  = (state_q == WRITE);
      resp_c.b_valid  = (state_q == WRITE_RESP);
      resp_c.r_valid  = (state_q == READ);
      if (state_q == WRITE_RESP) begin
         resp_c.b.id   = id_q;
         resp_c.b.resp = oob ? RespSlvErr : RespOkay;
      end
      if (state_q == READ) begin
         resp_c.r.id   = id_q;
         resp_c.r.data = oob ? '0 : mem_q[idx];
         resp_c.r.resp = oob ? RespSlvErr : RespOkay;
         resp_c.r.last = (beat_q == len_q);
      end
   end

endmodule
